// File: rtl/time_entry_controller.sv
// Keypad time-entry sequencer: walks HOUR -> MIN -> SEC on '#', stages two BCD digits
// per field, range-checks each field and strobes time_load once a full valid time is entered.
module time_entry_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
    parameter int unsigned TO_W           = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_start,
    input  logic [9:0] keypad,
    input  logic       sharp,
    input  logic       star,
    output logic [3:0] hour_ten_out,
    output logic [3:0] hour_one_out,
    output logic [3:0] min_ten_out,
    output logic [3:0] min_one_out,
    output logic [3:0] sec_ten_out,
    output logic [3:0] sec_one_out,
    output logic [1:0] field,
    output logic       busy,
    output logic       time_load,
    output logic       err_pulse,
    output logic       abort_pulse
);

    typedef enum logic [2:0] {S_IDLE, S_HOUR, S_MIN, S_SEC, S_LOAD} state_t;

    state_t            state, state_n;
    logic [9:0]        key_d;
    logic              sharp_d, star_d, start_d;
    logic [2:0][3:0]   ten_q, one_q, ten_n, one_n;
    logic [TO_W-1:0]   cnt, cnt_n;
    logic              load_n, err_n, abort_n;
    logic [1:0]        field_n;

    logic              key_ev, sharp_ev, star_ev, start_ev;
    logic [3:0]        digit;
    logic [1:0]        fidx;
    logic [6:0]        value;
    logic [6:0]        limit;

    assign key_ev   = (|keypad) && !(|key_d);
    assign sharp_ev = sharp && !sharp_d;
    assign star_ev  = star && !star_d;
    assign start_ev = set_start && !start_d;

    always_comb begin
        digit = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (keypad[i]) digit = 4'(i);
        end
    end

    always_comb begin
        fidx  = 2'd0;
        limit = 7'd23;
        case (state)
            S_MIN:   begin fidx = 2'd1; limit = 7'd59; end
            S_SEC:   begin fidx = 2'd2; limit = 7'd59; end
            default: begin fidx = 2'd0; limit = 7'd23; end
        endcase
    end

    assign value = 7'(ten_q[fidx]) * 7'd10 + 7'(one_q[fidx]);

    always_comb begin
        state_n = state;
        ten_n   = ten_q;
        one_n   = one_q;
        cnt_n   = cnt;
        load_n  = 1'b0;
        err_n   = 1'b0;
        abort_n = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (start_ev) begin
                    ten_n   = '0;
                    one_n   = '0;
                    state_n = S_HOUR;
                end
            end
            S_HOUR, S_MIN, S_SEC: begin
                // star beats sharp beats digit; losers in the same cycle are dropped
                if (star_ev) begin
                    abort_n = 1'b1;
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else if (sharp_ev) begin
                    cnt_n = '0;
                    if (value <= limit) begin
                        case (state)
                            S_HOUR:  state_n = S_MIN;
                            S_MIN:   state_n = S_SEC;
                            default: begin state_n = S_LOAD; load_n = 1'b1; end
                        endcase
                    end else begin
                        ten_n[fidx] = '0;
                        one_n[fidx] = '0;
                        err_n       = 1'b1;
                    end
                end else if (key_ev) begin
                    cnt_n = '0;
                    if ($onehot(keypad)) begin
                        ten_n[fidx] = one_q[fidx];
                        one_n[fidx] = digit;
                    end
                end else if (cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    abort_n = 1'b1;
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case (state_n)
            S_HOUR:  field_n = 2'd0;
            S_MIN:   field_n = 2'd1;
            S_SEC:   field_n = 2'd2;
            default: field_n = 2'd3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            key_d       <= '0;
            sharp_d     <= 1'b0;
            star_d      <= 1'b0;
            start_d     <= 1'b0;
            ten_q       <= '0;
            one_q       <= '0;
            cnt         <= '0;
            field       <= 2'd3;
            busy        <= 1'b0;
            time_load   <= 1'b0;
            err_pulse   <= 1'b0;
            abort_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            key_d       <= keypad;
            sharp_d     <= sharp;
            star_d      <= star;
            start_d     <= set_start;
            ten_q       <= ten_n;
            one_q       <= one_n;
            cnt         <= cnt_n;
            field       <= field_n;
            busy        <= (state_n != S_IDLE);
            time_load   <= load_n;
            err_pulse   <= err_n;
            abort_pulse <= abort_n;
        end
    end

    assign hour_ten_out = ten_q[0];
    assign hour_one_out = one_q[0];
    assign min_ten_out  = ten_q[1];
    assign min_one_out  = one_q[1];
    assign sec_ten_out  = ten_q[2];
    assign sec_one_out  = one_q[2];

endmodule
